mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// Schedules one shared single-port memory between the pipeline's IF stage (instruction fetch) and MEM stage (lw/sw).
// Each access has a fixed multi-cycle latency. The block drives the memory port and returns read data.
// It produces stall_if / stall_mem, which the hazard logic uses to freeze the pipeline while a stage waits.
// PARAMETERS
// ADDR_W   32  memory address width
// DATA_W   32  memory data width
// MEM_LAT  2   cycles from mem_en pulse to valid mem_rdata; legal range 1..15
// PORTS
// clk        in   1       clock, rising edge
// rst_n      in   1       asynchronous, active-low reset
// if_req     in   1       fetch request; held until if_ready
// if_addr    in   ADDR_W  fetch address (PC)
// if_rdata   out  DATA_W  fetched instruction; valid while if_ready=1
// if_ready   out  1       one-cycle completion pulse for the fetch
// dm_read    in   1       MEM-stage load (control-unit memRead); held until dm_ready
// dm_write   in   1       MEM-stage store (control-unit memWrite); held until dm_ready
// dm_addr    in   ADDR_W  data address (ALU result)
// dm_wdata   in   DATA_W  store data
// dm_rdata   out  DATA_W  load data; valid while dm_ready=1
// dm_ready   out  1       one-cycle completion pulse for the data access
// mem_en     out  1       one-cycle access strobe to memory
// mem_we     out  1       write enable, qualified by mem_en
// mem_addr   out  ADDR_W  memory address, held stable for the whole access
// mem_wdata  out  DATA_W  memory write data, held stable for the whole access
// mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
// stall_if   out  1       combinational: if_req & ~if_ready
// stall_mem  out  1       combinational: (dm_read|dm_write) & ~dm_ready
// BEHAVIOUR
// - Reset values: state=IDLE, last_grant=IF, cnt=0, all registered outputs 0 (including mem_*, *_ready, *_rdata).
// - FSM states
//   - IDLE: no access in flight.
//   - IF_ACC: fetch in flight.
//   - DM_ACC: data access in flight.
// - Grant decision is taken in IDLE, or in the completion cycle of an IF_ACC/DM_ACC access.
//   - Only one requester pending: it is granted.
//   - Both pending: the one NOT equal to last_grant is granted, so a tie after reset goes to DM. This gives round-robin and neither stage starves.
// - Grant cycle G: latch addr/wdata/we into the mem_* registers; update last_grant.
//   - Cycle G+1: mem_en=1 for exactly one cycle.
//   - Cycle G+1+MEM_LAT: capture mem_rdata into if_rdata or dm_rdata and pulse the matching *_ready.
//   - Completion cycle G+1+MEM_LAT is also a grant cycle: back-to-back accesses have no idle bubble.
// - Single isolated request asserted in cycle 0 from IDLE: mem_en in cycle 1, ready in cycle MEM_LAT+1.
// - cnt: loaded with MEM_LAT at the mem_en cycle, decremented each cycle; completion when cnt==1. Width is 4 bits.
// - dm_read and dm_write both high: treated as a write (mem_we=1); dm_rdata is undefined in that case.
// - Write completion still pulses dm_ready. dm_rdata is don't-care on a write.
// - Request dropped before completion (pipeline flush): the access still completes at the memory, so writes are never torn.
//   - The *_ready pulse is suppressed if the request is low in the completion cycle.
//   - The FSM proceeds to the next grant decision as normal.
// - Requester must hold addr/wdata stable until ready; changes after the grant cycle are ignored.
// - rst_n asserted mid-access: immediate return to the reset values; the in-flight access is abandoned and no ready pulse is issued.
// - No request pending in a completion cycle: go to IDLE.
// STRUCTURE
// - mips_pkg holds:
//   - typedef enum logic[1:0] {ARB_IDLE, ARB_IF, ARB_DM} arb_state_t;
//   - typedef enum logic {GNT_IF, GNT_DM} arb_grant_t;
//   - localparam MEM_LAT_MAX = 15.
// - Sub-module mem_lat_counter (load, dec, done flag) holds the latency count. FSM, grant logic and data registers stay in mem_arbiter.
// TESTING
// - MEM_LAT=2; if_req=1, if_addr=0x40 alone -> mem_en in cycle 1 with mem_addr=0x40; if_ready in cycle 3 with if_rdata=mem_rdata.
// - if_req and dm_read asserted together right after reset -> DM granted first; IF mem_en follows immediately after dm_ready, with no idle cycle.
// - Both requests held continuously for 6 accesses -> grants alternate DM, IF, DM, IF, DM, IF.
// - dm_write=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> one mem_en with mem_we=1 and those values; dm_ready pulses; stall_mem drops in the same cycle.
// - Drop if_req one cycle after its mem_en -> access completes, no if_ready pulse, next pending dm request is granted in the completion cycle.
// - Pull rst_n low during DM_ACC -> all outputs 0 asynchronously; after release, a new IF request completes in MEM_LAT+1 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory arbiter
package mips_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_DM} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DM} arb_grant_t;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  // On a tie the stage that did not win last time goes next, so neither starves.
  function automatic arb_grant_t pick_grant(input logic if_pend, input logic dm_pend,
                                            input arb_grant_t last);
    arb_grant_t g;
    if (if_pend && dm_pend) g = (last == GNT_IF) ? GNT_DM : GNT_IF;
    else if (dm_pend)       g = GNT_DM;
    else                    g = GNT_IF;
    return g;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - latency down-counter; done while the count sits at one
module mem_lat_counter
  import mips_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin scheduler of the shared memory port between fetch and load/store
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int LAT = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : ((MEM_LAT < 1) ? 1 : MEM_LAT);

  arb_state_t        r_state;
  arb_grant_t        r_last_grant;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic       w_cnt_done;
  logic       w_dm_req;
  logic       w_if_done;
  logic       w_dm_done;
  logic       w_if_pend;
  logic       w_dm_pend;
  logic       w_decide;
  logic       w_grant_any;
  arb_grant_t w_grant;

  mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_mem_en),
    .i_dec      (r_state != ARB_IDLE),
    .i_load_val (CNT_W'(LAT)),
    .o_done     (w_cnt_done)
  );

  assign w_dm_req  = dm_read | dm_write;
  assign w_if_done = (r_state == ARB_IF) & w_cnt_done;
  assign w_dm_done = (r_state == ARB_DM) & w_cnt_done;

  // The requester being completed this cycle is satisfied and must not be re-granted.
  assign w_if_pend   = if_req & ~w_if_done;
  assign w_dm_pend   = w_dm_req & ~w_dm_done;
  assign w_decide    = (r_state == ARB_IDLE) | w_if_done | w_dm_done;
  assign w_grant_any = w_decide & (w_if_pend | w_dm_pend);
  assign w_grant     = pick_grant(w_if_pend, w_dm_pend, r_last_grant);

  assign if_ready  = w_if_done & if_req;
  assign dm_ready  = w_dm_done & w_dm_req;
  assign if_rdata  = if_ready ? mem_rdata : r_if_rdata;
  assign dm_rdata  = dm_ready ? mem_rdata : r_dm_rdata;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = w_dm_req & ~dm_ready;

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GNT_IF;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_mem_en <= 1'b0;
      if (if_ready) r_if_rdata <= mem_rdata;
      if (dm_ready) r_dm_rdata <= mem_rdata;
      if (w_decide) begin
        if (w_grant_any) begin
          r_last_grant <= w_grant;
          r_mem_en     <= 1'b1;
          if (w_grant == GNT_DM) begin
            r_state     <= ARB_DM;
            r_mem_we    <= dm_write;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
          end else begin
            r_state    <= ARB_IF;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr;
          end
        end else begin
          r_state <= ARB_IDLE;
        end
      end
    end
  end

endmodule
